frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Distributes the pixels of one frame, in raster order, across `NUM_CORES` ray-marcher cores. It tracks which cores are busy and detects frame completion. When a frame finishes it emits the single-cycle `new_frame_out` pulse consumed by `fps_counter`. It sits between the frame-level control (enable) and the core array, and is the sole source of pixel coordinates for the cores.

## Interface
Parameters:
- `H_COUNT`, 320: pixels per line.
- `V_COUNT`, 240: lines per frame.
- `NUM_CORES`, 4: number of ray-marcher cores, ≥1.
- `FRAME_ID_WIDTH`, 16: width of the frame counter.

Ports:
- `clk_in`, input, 1: single system clock.
- `rst_in`, input, 1: reset; synchronous, active-high.
- `enable_in`, input, 1: level; permits starting a new frame.
- `core_done_in`, input, NUM_CORES: per-core one-cycle pulse, pixel finished.
- `dispatch_out`, output, NUM_CORES: one-hot or zero; one-cycle pulse granting a pixel to core i.
- `hcount_out`, output, $clog2(H_COUNT): pixel x, valid when `dispatch_out` is nonzero.
- `vcount_out`, output, $clog2(V_COUNT): pixel y, valid when `dispatch_out` is nonzero.
- `new_frame_out`, output, 1: one-cycle pulse, frame complete.
- `frame_id_out`, output, FRAME_ID_WIDTH: completed-frame count.
- `busy_out`, output, 1: high in any state other than IDLE.

## Operation
- Reset: state IDLE. `busy[]`=0, rr pointer=0, pixel counters=0. All outputs 0.
- The block keeps an internal `busy[i]` per core. Core i is available iff `!busy[i]`.
- States and transitions:
  - IDLE: if `enable_in`, go to DISPATCH with counters (0,0).
  - DISPATCH: if any core is available, grant exactly one via round-robin.
    - Search starts at last grant + 1, modulo NUM_CORES.
    - Register `dispatch_out`, `hcount_out`, `vcount_out`, set `busy[grant]`, advance counters.
    - `hcount` wraps at H_COUNT−1 and increments `vcount`.
    - Granting pixel (H_COUNT−1, V_COUNT−1) moves to DRAIN.
  - DRAIN: no dispatches. When `busy[]`==0, go to FLIP.
  - FLIP: pulse `new_frame_out`, increment `frame_id_out` (wraps modulo 2^FRAME_ID_WIDTH). Next state is DISPATCH with counters (0,0) if `enable_in`, else IDLE.
- `core_done_in[i]` clears `busy[i]` in every state, including IDLE.
  - A done pulse for a non-busy core is ignored.
  - Done and set for the same core in the same cycle cannot occur: the grant requires `!busy`.
  - Done for core i may coincide with a grant to core j≠i; both take effect.
- Dropping `enable_in` mid-frame has no effect; the current frame completes. Only `rst_in` aborts.
- `rst_in` mid-frame discards all outstanding work. Late `core_done_in` pulses after reset are ignored.

## Timing
- All outputs are registered.
- `enable_in` sampled high in IDLE at edge k: first `dispatch_out` visible after edge k+1.
- Throughput: at most one dispatch per cycle. With ≥1 free core each cycle, dispatches are back-to-back.
- A `core_done_in` sampled at edge k makes that core grantable at edge k+1, so its dispatch is visible after k+1.
- DRAIN→FLIP: the cycle after `busy[]` reads zero. `new_frame_out` is high exactly one cycle.
- FLIP→DISPATCH: next frame's first dispatch is visible one cycle after `new_frame_out`.
- Minimum frame period with instant cores (done the cycle after dispatch) and NUM_CORES≥2: H_COUNT·V_COUNT + 3 cycles.

## Structure
- `frame_scheduler_pkg`:
  - state enum `sched_state_t` {IDLE, DISPATCH, DRAIN, FLIP};
  - localparams for the coordinate widths.
- Sub-module `rr_arbiter` (parameter N):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant valid, next pointer;
  - combinational, instantiated once.

## Test plan
- Reset mid-DISPATCH with 2 busy cores:
  - All outputs 0 next cycle, state IDLE.
  - Late `core_done_in` ignored.
  - The next frame starts at (0,0).
- H=4, V=2, NUM_CORES=2, cores answer 1 cycle after dispatch, `enable_in`=1:
  - Grants alternate core0/core1 over 8 pixels in raster order (0,0)…(3,1).
  - `new_frame_out` once; `frame_id_out`=1.
  - 11-cycle frame period repeats.
- NUM_CORES=4, all cores withhold done:
  - Exactly 4 dispatches (cores 0,1,2,3), then stall.
  - Releasing core2 yields the next dispatch, to core2, at pixel (0,1) for H=4.
- Drop `enable_in` after the third dispatch:
  - The frame still completes all H·V pixels.
  - `new_frame_out` pulses once, then IDLE, `busy_out`=0, no further dispatch.
- Spurious `core_done_in` to an idle core, and simultaneous done(core0) with grant(core1):
  - No double grant; `dispatch_out` always one-hot or zero.
  - Total dispatches per frame = H·V.
- FRAME_ID_WIDTH=2, run 5 frames:
  - `frame_id_out` sequence 1,2,3,0,1.
  - Connect `new_frame_out` to `fps_counter`; with a fixed frame period P, `fps_out` equals ONE_SECOND_CYCLES/P.

Source files
------------

// File: rtl/frame_scheduler_pkg.sv
// Shared types and helpers for the frame scheduler: FSM state encoding,
// default frame geometry and index-width helper.
package frame_scheduler_pkg;

   // Scheduler phases: wait for enable, hand out pixels, wait for the
   // cores to finish, then announce the completed frame.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      FLIP     = 2'd3
   } sched_state_t;

   // Default frame geometry.
   localparam int DEFAULT_H_COUNT = 320;
   localparam int DEFAULT_V_COUNT = 240;

   // Width of an index into n items; never below one bit so that a
   // single-core build still has a legal pointer register.
   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter. Searches the request vector starting at
// ptr, wrapping modulo N, and returns a one-hot grant plus the pointer one
// past the winner so the next search starts after the last grant.
module rr_arbiter
   import frame_scheduler_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]                 req,
   input  logic [index_width(N)-1:0]    ptr,
   output logic [N-1:0]                 grant,
   output logic                         valid,
   output logic [index_width(N)-1:0]    next_ptr
);

   localparam int PW = index_width(N);

   int idx;

   // First requester at or after ptr wins; later candidates are masked by valid.
   always_comb begin
      grant    = '0;
      valid    = 1'b0;
      next_ptr = ptr;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!valid && ((req & (N'(1) << idx)) != '0)) begin
            grant    = N'(1) << idx;
            valid    = 1'b1;
            next_ptr = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: walks one frame in raster order, granting each pixel to a
// free ray-marcher core chosen round-robin, tracks per-core busy bits, and
// pulses new_frame_out once every pixel of the frame has been finished.
module frame_scheduler
   import frame_scheduler_pkg::*;
#(
   parameter int H_COUNT        = DEFAULT_H_COUNT,
   parameter int V_COUNT        = DEFAULT_V_COUNT,
   parameter int NUM_CORES      = 4,
   parameter int FRAME_ID_WIDTH = 16
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        enable_in,
   input  logic [NUM_CORES-1:0]        core_done_in,
   output logic [NUM_CORES-1:0]        dispatch_out,
   output logic [$clog2(H_COUNT)-1:0]  hcount_out,
   output logic [$clog2(V_COUNT)-1:0]  vcount_out,
   output logic                        new_frame_out,
   output logic [FRAME_ID_WIDTH-1:0]   frame_id_out,
   output logic                        busy_out
);

   localparam int HW = $clog2(H_COUNT);
   localparam int VW = $clog2(V_COUNT);
   localparam int PW = index_width(NUM_CORES);
   localparam logic [HW-1:0] H_LAST = HW'(H_COUNT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_COUNT - 1);

   sched_state_t          state;
   logic [NUM_CORES-1:0]  busy;
   logic [NUM_CORES-1:0]  avail;
   logic [NUM_CORES-1:0]  grant;
   logic [NUM_CORES-1:0]  grant_now;
   logic                  grant_valid;
   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         rr_next;
   logic [HW-1:0]         h_cnt;
   logic [VW-1:0]         v_cnt;
   logic                  last_pixel;

   // A core can take a pixel only when it holds none; a done pulse takes a
   // cycle to land in busy, so a finished core is grantable one edge later.
   assign avail = ~busy;

   rr_arbiter #(
      .N (NUM_CORES)
   ) u_arb (
      .req      (avail),
      .ptr      (rr_ptr),
      .grant    (grant),
      .valid    (grant_valid),
      .next_ptr (rr_next)
   );

   // Grants only take effect while distributing pixels.
   assign grant_now  = (state == DISPATCH) ? grant : '0;
   assign last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST);

   // Scheduler FSM with registered outputs, busy tracking and raster counters.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= IDLE;
         busy          <= '0;
         rr_ptr        <= '0;
         h_cnt         <= '0;
         v_cnt         <= '0;
         dispatch_out  <= '0;
         hcount_out    <= '0;
         vcount_out    <= '0;
         new_frame_out <= 1'b0;
         frame_id_out  <= '0;
         busy_out      <= 1'b0;
      end else begin
         dispatch_out  <= '0;
         new_frame_out <= 1'b0;
         // Done clears in every state; a grant can only target a non-busy
         // core, so a done for another core and a grant never collide.
         busy <= (busy & ~core_done_in) | grant_now;
         case (state)
            IDLE: begin
               if (enable_in) begin
                  state    <= DISPATCH;
                  h_cnt    <= '0;
                  v_cnt    <= '0;
                  busy_out <= 1'b1;
               end
            end
            DISPATCH: begin
               if (grant_valid) begin
                  dispatch_out <= grant;
                  hcount_out   <= h_cnt;
                  vcount_out   <= v_cnt;
                  rr_ptr       <= rr_next;
                  if (h_cnt == H_LAST) begin
                     h_cnt <= '0;
                     v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                  end else begin
                     h_cnt <= h_cnt + HW'(1);
                  end
                  if (last_pixel) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (busy == '0) begin
                  state <= FLIP;
               end
            end
            FLIP: begin
               new_frame_out <= 1'b1;
               frame_id_out  <= frame_id_out + FRAME_ID_WIDTH'(1);
               h_cnt         <= '0;
               v_cnt         <= '0;
               if (enable_in) begin
                  state <= DISPATCH;
               end else begin
                  state    <= IDLE;
                  busy_out <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler on a small 4x2 frame with four cores and a 2-bit
// frame id. A cycle model of the scheduling rules predicts every output; a
// set of fixed scenarios pins raster order, round-robin, frame period and
// frame id wrap with literal values.
module tb_frame_scheduler;

   localparam int H  = 4;
   localparam int V  = 2;
   localparam int N  = 4;
   localparam int FW = 2;
   localparam int HW = $clog2(H);
   localparam int VW = $clog2(V);
   localparam int W  = 16;

   localparam int C_INSTANT = 0;
   localparam int C_RANDOM  = 1;
   localparam int C_HOLD    = 2;

   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_WAIT = 2;
   localparam int M_DONE = 3;

   // ---------------- clock / DUT ----------------
   logic           clk = 1'b0;
   logic           rst;
   logic           en;
   logic [N-1:0]   done;
   logic [N-1:0]   dispatch;
   logic [HW-1:0]  hc;
   logic [VW-1:0]  vc;
   logic           nf;
   logic [FW-1:0]  fid;
   logic           bsy;

   initial forever #5 clk = ~clk;

   frame_scheduler #(
      .H_COUNT        (H),
      .V_COUNT        (V),
      .NUM_CORES      (N),
      .FRAME_ID_WIDTH (FW)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .enable_in     (en),
      .core_done_in  (done),
      .dispatch_out  (dispatch),
      .hcount_out    (hc),
      .vcount_out    (vc),
      .new_frame_out (nf),
      .frame_id_out  (fid),
      .busy_out      (bsy)
   );

   // ---------------- bookkeeping ----------------
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // scenario knobs, written by the main sequence at posedges
   bit           knob_rst  = 1'b1;
   bit           knob_en   = 1'b0;
   bit           knob_spur = 1'b0;
   int           core_mode = C_INSTANT;
   logic [N-1:0] release_mask = '0;

   // core models
   bit held[N];
   bit hold_forever[N];
   int timer[N];

   // observation logs
   int d_core[$];
   int d_h[$];
   int d_v[$];
   int nf_cyc[$];
   int fid_seen[$];
   int nf_count   = 0;
   int frame_disp = 0;

   // reference model
   int             m_phase = M_IDLE;
   int             m_last  = N - 1;
   int             m_sent  = 0;
   logic [N-1:0]   m_busy  = '0;
   logic [N-1:0]   exp_dispatch = '0;
   logic           exp_nf  = 1'b0;
   logic           exp_bsy = 1'b0;
   logic [FW-1:0]  exp_fid = '0;
   logic [W-1:0]   exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Core the model would grant next, or -1.
   function automatic int model_next_grant();
      if (m_phase != M_RUN) return -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (m_last + k) % N;
         if (!m_busy[c]) return c;
      end
      return -1;
   endfunction

   // Advance the model by one clock edge given the inputs sampled there.
   task automatic model_step(input bit r, input bit e, input logic [N-1:0] dn);
      logic [N-1:0] gbit;
      int           g;
      gbit         = '0;
      exp_dispatch = '0;
      exp_nf       = 1'b0;
      if (r) begin
         m_phase = M_IDLE;
         m_busy  = '0;
         m_last  = N - 1;
         m_sent  = 0;
         exp_fid = '0;
         exp_bsy = 1'b0;
         exp_q.delete();
         return;
      end
      case (m_phase)
         M_IDLE: begin
            if (e) begin
               m_phase = M_RUN;
               m_sent  = 0;
            end
         end
         M_RUN: begin
            g = model_next_grant();
            if (g >= 0) begin
               gbit         = N'(1) << g;
               exp_dispatch = gbit;
               exp_q.push_back(W'(((m_sent / H) << 8) | (m_sent % H)));
               m_last = g;
               m_sent++;
               if (m_sent == H * V) m_phase = M_WAIT;
            end
         end
         M_WAIT: begin
            if (m_busy == '0) m_phase = M_DONE;
         end
         default: begin
            exp_nf  = 1'b1;
            exp_fid = FW'((int'(exp_fid) + 1) % (1 << FW));
            m_sent  = 0;
            m_phase = e ? M_RUN : M_IDLE;
         end
      endcase
      m_busy  = (m_busy & ~dn) | gbit;
      exp_bsy = (m_phase != M_IDLE);
   endtask

   // Compare every output against the model prediction for this cycle.
   task automatic check_outputs();
      logic [W-1:0] pix;
      check("dispatch", 32'(dispatch), 32'(exp_dispatch));
      check("new_frame", 32'(nf), 32'(exp_nf));
      check("frame_id", 32'(fid), 32'(exp_fid));
      check("busy_out", 32'(bsy), 32'(exp_bsy));
      if (exp_dispatch != '0) begin
         pix = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
         check("hcount", 32'(hc), 32'(pix[7:0]));
         check("vcount", 32'(vc), 32'(pix[15:8]));
      end
   endtask

   task automatic log_events();
      if (dispatch != '0) begin
         for (int i = 0; i < N; i++) if (dispatch[i]) d_core.push_back(i);
         d_h.push_back(int'(hc));
         d_v.push_back(int'(vc));
         frame_disp++;
      end
      if (nf) begin
         nf_cyc.push_back(cyc);
         fid_seen.push_back(int'(fid));
         check("pixels_per_frame", 32'(frame_disp), 32'(H * V));
         frame_disp = 0;
         nf_count++;
      end
   endtask

   // Core behaviour: latch dispatches, answer after a latency or on release,
   // and optionally inject done pulses to cores holding no pixel.
   task automatic drive_inputs();
      logic [N-1:0] d;
      int           g;
      d = '0;
      g = model_next_grant();
      for (int i = 0; i < N; i++) begin
         if (dispatch[i]) begin
            held[i] = 1'b1;
            hold_forever[i] = (core_mode == C_HOLD);
            timer[i] = (core_mode == C_RANDOM) ? int'($urandom_range(0, 4)) : 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (held[i]) begin
            if (hold_forever[i]) begin
               if (release_mask[i]) begin
                  d[i] = 1'b1;
                  held[i] = 1'b0;
                  hold_forever[i] = 1'b0;
               end
            end else if (timer[i] == 0) begin
               d[i] = 1'b1;
               held[i] = 1'b0;
            end else begin
               timer[i]--;
            end
         end else if (knob_spur && i != g && $urandom_range(0, 5) == 0) begin
            d[i] = 1'b1;
         end
      end
      rst  = knob_rst;
      en   = knob_en;
      done = d;
      if (knob_rst) frame_disp = 0;
   endtask

   task automatic clear_logs();
      d_core.delete();
      d_h.delete();
      d_v.delete();
      nf_cyc.delete();
      fid_seen.delete();
      nf_count = 0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int start;
      start = nf_count;
      for (int c = 0; c < budget && nf_count < start + n; c++) @(posedge clk);
      check("frames_seen", 32'(nf_count - start), 32'(n));
   endtask

   // Per-cycle scoreboard process on the falling edge.
   initial begin
      for (int i = 0; i < N; i++) begin
         held[i] = 1'b0;
         hold_forever[i] = 1'b0;
         timer[i] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         check_outputs();
         log_events();
         drive_inputs();
         model_step(rst, en, done);
      end
   end

   // Main sequence.
   initial begin
      int exp_fid_seq[5];
      int nf_before;
      int disp_before;
      exp_fid_seq = '{1, 2, 3, 0, 1};
      rst  = 1'b1;
      en   = 1'b0;
      done = '0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_dispatch", 32'(dispatch), 32'd0);
      check("reset_hcount", 32'(hc), 32'd0);
      check("reset_vcount", 32'(vc), 32'd0);
      check("reset_new_frame", 32'(nf), 32'd0);
      check("reset_frame_id", 32'(fid), 32'd0);
      check("reset_busy_out", 32'(bsy), 32'd0);

      // instant cores, enable held: raster order, rotation, period, id wrap
      @(posedge clk);
      clear_logs();
      knob_rst  = 1'b0;
      knob_en   = 1'b1;
      core_mode = C_INSTANT;
      wait_frames(5, 200);
      if (fid_seen.size() >= 5) begin
         for (int k = 0; k < 5; k++) check("frame_id_seq", 32'(fid_seen[k]), 32'(exp_fid_seq[k]));
         for (int k = 1; k < 5; k++) check("frame_period", 32'(nf_cyc[k] - nf_cyc[k-1]), 32'd11);
      end else begin
         check("frame_id_count", 32'(fid_seen.size()), 32'd5);
      end
      if (d_core.size() >= 8) begin
         for (int p = 0; p < 8; p++) begin
            check("first_frame_core", 32'(d_core[p]), 32'(p % 4));
            check("first_frame_h", 32'(d_h[p]), 32'(p % 4));
            check("first_frame_v", 32'(d_v[p]), 32'(p / 4));
         end
      end else begin
         check("first_frame_dispatches", 32'(d_core.size()), 32'd8);
      end

      // cores withhold done: four grants then stall; release core 2
      @(posedge clk);
      knob_rst  = 1'b1;
      knob_en   = 1'b0;
      core_mode = C_HOLD;
      repeat (2) @(posedge clk);
      clear_logs();
      knob_rst = 1'b0;
      knob_en  = 1'b1;
      repeat (12) @(posedge clk);
      check("stall_dispatches", 32'(d_core.size()), 32'd4);
      if (d_core.size() >= 4) begin
         for (int p = 0; p < 4; p++) begin
            check("stall_core", 32'(d_core[p]), 32'(p));
            check("stall_h", 32'(d_h[p]), 32'(p));
            check("stall_v", 32'(d_v[p]), 32'd0);
         end
      end
      release_mask = 4'b0100;
      @(posedge clk);
      release_mask = '0;
      repeat (4) @(posedge clk);
      check("release_dispatches", 32'(d_core.size()), 32'd5);
      if (d_core.size() >= 5) begin
         check("release_core", 32'(d_core[4]), 32'd2);
         check("release_h", 32'(d_h[4]), 32'd0);
         check("release_v", 32'(d_v[4]), 32'd1);
      end

      // reset mid-frame with busy cores, then late done pulses
      knob_rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("midreset_dispatch", 32'(dispatch), 32'd0);
      check("midreset_busy_out", 32'(bsy), 32'd0);
      check("midreset_frame_id", 32'(fid), 32'd0);
      @(posedge clk);
      clear_logs();
      knob_rst     = 1'b0;
      knob_en      = 1'b0;
      core_mode    = C_RANDOM;
      release_mask = '1;
      @(posedge clk);
      release_mask = '0;
      repeat (3) @(posedge clk);
      #1;
      check("late_done_busy_out", 32'(bsy), 32'd0);
      check("late_done_dispatches", 32'(d_core.size()), 32'd0);

      // random latency with spurious done pulses
      @(posedge clk);
      clear_logs();
      knob_en   = 1'b1;
      knob_spur = 1'b1;
      wait_frames(3, 400);
      if (d_core.size() > 0) begin
         check("restart_core", 32'(d_core[0]), 32'd0);
         check("restart_h", 32'(d_h[0]), 32'd0);
         check("restart_v", 32'(d_v[0]), 32'd0);
      end

      // drop enable after the third dispatch of a frame
      for (int c = 0; c < 100 && frame_disp < 3; c++) @(posedge clk);
      check("third_dispatch_seen", 32'(frame_disp >= 3), 32'd1);
      knob_en   = 1'b0;
      nf_before = nf_count;
      for (int c = 0; c < 200 && nf_count == nf_before; c++) @(posedge clk);
      check("drop_enable_frame_done", 32'(nf_count - nf_before), 32'd1);
      disp_before = d_core.size();
      repeat (20) @(posedge clk);
      #1;
      check("drop_enable_busy_out", 32'(bsy), 32'd0);
      check("drop_enable_no_dispatch", 32'(d_core.size() - disp_before), 32'd0);
      check("drop_enable_one_frame", 32'(nf_count - nf_before), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
